step_pulse_gen: RTL
===================

Name: step_pulse_gen

Overview:
- Downstream stage of the speed selector: consumes the 3-bit speed code (1..6 = 10..60 rpm) and drives a 4-coil unipolar/bipolar stepper driver.
- Converts the code into a step period and walks the coil excitation sequence.
- Emits a one-cycle step strobe per step and reports the speed code currently in effect.
- Speed and direction changes are applied only at step boundaries, so the coil timing never glitches.

Parameters:
- CYC_10RPM, 1500000, clock cycles per step at 10 rpm (50 MHz, 200 steps/rev); period for code k = CYC_10RPM / k, integer truncation, constant at elaboration.
- CNT_W, 24, period counter width; must hold CYC_10RPM-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- en  input  1  run enable
- dir  input  1  1 = forward (phase index +1), 0 = reverse (index -1)
- speed_in  input  3  speed code from selector; 1..6 valid, 0/7 invalid
- coil_out  output  4  coil drive pattern {A,B,C,D}, registered
- step_pulse  output  1  one-cycle strobe on each phase advance
- running  output  1  high while in RUN
- speed_cur  output  3  latched speed code in effect (0 in IDLE)

Behaviour:
- One clock. Reset is asynchronous, active-low on rst. All state updates on posedge clk.
- Reset values: state=IDLE, phase index=0, counter=0, coil_out=0000, step_pulse=0, running=0, speed_cur=000.
- Full-step table (two-phase-on), index 0..3: 1100, 0110, 0011, 1001.
- FSM has two states.
  - IDLE: coil_out=0000, counter held at 0, phase index retained. If en=1 and speed_in is valid, latch speed_in into speed_cur and go to RUN. Otherwise stay.
  - RUN: coil_out=table[index] and running=1, both registered. They become valid in the cycle after the IDLE->RUN edge, i.e. latency 1 from en/speed sampling.
- Period counter: counts 0..P-1, with P = CYC_10RPM / speed_cur. Period comes from a 6-entry constant lookup; no runtime divider.
- Step boundary (counter = P-1):
  - Counter -> 0.
  - Index advances per dir sampled that cycle, modulo the table length (3+1 -> 0, 0-1 -> 3).
  - step_pulse=1 for exactly the next cycle, coincident with the new coil_out.
  - speed_in is re-latched into speed_cur.
- Invalid speed_in sampled at a step boundary: no advance, no pulse; go to IDLE. coil_out=0000 and speed_cur=0 on the next cycle.
- en=0 in RUN: immediate abort to IDLE on the next cycle, with no pulse. Counter cleared; index retained, so re-entry resumes the same phase.
- speed_in or dir changes mid-period have no effect until the next boundary.
- en=1 and boundary in the same cycle: boundary processing happens normally. en=0 at the boundary aborts and suppresses the advance.
- step_pulse never asserts in IDLE and never asserts on two consecutive cycles.
- Asserting rst mid-period returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: STEP_PULSE_GEN_HALF_STEP_EN.
- Defined:
  - 8-entry half-step table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Period = (CYC_10RPM / k) / 2, truncated. This keeps the same rpm at double step resolution.
  - Index wraps modulo 8; reset index = 0.
- Undefined: full-step 4-entry table and period as above. The half-step logic is not present in the netlist.

Test Plan:
- CYC_10RPM=60, rst low then high, en=1, speed_in=1, dir=1 -> coil_out=1100 one cycle after en. step_pulse every 60 cycles. Sequence 0110, 0011, 1001, 1100 (wrap). speed_cur=1.
- Same setup, switch speed_in 1->6 mid-period -> current 60-cycle period completes. From then on, pulses every 10 cycles and speed_cur=6. No short or long period at the switch.
- dir=0 from index 0 at speed 3 -> coil_out 1100, 1001, 0011, 0110, with 20 cycles between step_pulses.
- en dropped 5 cycles into a period, then re-raised with speed 2:
  - coil_out=0000, running=0, and no pulse on the drop.
  - On re-enable, the pattern resumes at the retained index and the first pulse comes 30 cycles later.
- speed_in=0 while running -> at the next boundary: no pulse, IDLE, coil_out=0000, speed_cur=0. With en=1 and speed_in=7, the block stays in IDLE.
- With STEP_PULSE_GEN_HALF_STEP_EN, speed 1, dir=1 -> pulses every 30 cycles. coil_out walks 1000, 1100, 0100, ..., 1001, then 1000. An async rst mid-period clears all outputs immediately.

Source files
------------

// File: rtl/step_pulse_gen.sv
// Stepper phase sequencer: turns a speed code into a step period and walks the coil table.
// Define STEP_PULSE_GEN_HALF_STEP_EN for the 8-entry half-step table at half the step period.
module step_pulse_gen #(
    parameter int CYC_10RPM = 1500000,
    parameter int CNT_W     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic [2:0] speed_in,
    output logic [3:0] coil_out,
    output logic       step_pulse,
    output logic       running,
    output logic [2:0] speed_cur
);

`ifdef STEP_PULSE_GEN_HALF_STEP_EN
    localparam int IDX_W   = 3;
    localparam int PER_DIV = 2;
`else
    localparam int IDX_W   = 2;
    localparam int PER_DIV = 1;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Terminal counts (period - 1) per speed code, fixed at elaboration.
    localparam logic [CNT_W-1:0] PER_M1_1 = CNT_W'((CYC_10RPM / 1) / PER_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_2 = CNT_W'((CYC_10RPM / 2) / PER_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_3 = CNT_W'((CYC_10RPM / 3) / PER_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_4 = CNT_W'((CYC_10RPM / 4) / PER_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_5 = CNT_W'((CYC_10RPM / 5) / PER_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_6 = CNT_W'((CYC_10RPM / 6) / PER_DIV - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       coil_q, coil_d;
    logic             pulse_q, pulse_d;
    logic             running_q, running_d;
    logic [2:0]       speed_q, speed_d;

    logic [CNT_W-1:0] period_m1;
    logic [IDX_W-1:0] idx_next;
    logic             speed_valid;

    function automatic logic [3:0] coil_of(input logic [IDX_W-1:0] idx);
        coil_of = 4'b0000;
`ifdef STEP_PULSE_GEN_HALF_STEP_EN
        case (idx)
            3'd0: coil_of = 4'b1000;
            3'd1: coil_of = 4'b1100;
            3'd2: coil_of = 4'b0100;
            3'd3: coil_of = 4'b0110;
            3'd4: coil_of = 4'b0010;
            3'd5: coil_of = 4'b0011;
            3'd6: coil_of = 4'b0001;
            3'd7: coil_of = 4'b1001;
            default: coil_of = 4'b0000;
        endcase
`else
        case (idx)
            2'd0: coil_of = 4'b1100;
            2'd1: coil_of = 4'b0110;
            2'd2: coil_of = 4'b0011;
            2'd3: coil_of = 4'b1001;
            default: coil_of = 4'b0000;
        endcase
`endif
    endfunction

    always_comb begin
        period_m1 = PER_M1_1;
        case (speed_q)
            3'd1: period_m1 = PER_M1_1;
            3'd2: period_m1 = PER_M1_2;
            3'd3: period_m1 = PER_M1_3;
            3'd4: period_m1 = PER_M1_4;
            3'd5: period_m1 = PER_M1_5;
            3'd6: period_m1 = PER_M1_6;
            default: period_m1 = PER_M1_1;
        endcase
    end

    assign speed_valid = (speed_in != 3'd0) && (speed_in != 3'd7);
    // Index width matches the table length, so wrap-around is the natural overflow.
    assign idx_next    = dir ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        coil_d    = coil_q;
        pulse_d   = 1'b0;
        running_d = running_q;
        speed_d   = speed_q;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                coil_d    = 4'b0000;
                running_d = 1'b0;
                speed_d   = 3'd0;
                if (en && speed_valid) begin
                    state_d   = S_RUN;
                    speed_d   = speed_in;
                    coil_d    = coil_of(idx_q);
                    running_d = 1'b1;
                end
            end
            S_RUN: begin
                if (!en) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    coil_d    = 4'b0000;
                    running_d = 1'b0;
                    speed_d   = 3'd0;
                end else if (cnt_q == period_m1) begin
                    // Speed and direction are only sampled here, keeping every period whole.
                    cnt_d = '0;
                    if (speed_valid) begin
                        idx_d   = idx_next;
                        coil_d  = coil_of(idx_next);
                        pulse_d = 1'b1;
                        speed_d = speed_in;
                    end else begin
                        state_d   = S_IDLE;
                        coil_d    = 4'b0000;
                        running_d = 1'b0;
                        speed_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            coil_q    <= 4'b0000;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            speed_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            coil_q    <= coil_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
            speed_q   <= speed_d;
        end
    end

    assign coil_out   = coil_q;
    assign step_pulse = pulse_q;
    assign running    = running_q;
    assign speed_cur  = speed_q;

endmodule
